// File: rtl/pkg_4004.sv
// Shared types and constants for the 4004 bus-cycle sequencer.
// Phases follow the 4004 instruction cycle order A1 A2 A3 M1 M2 X1 X2 X3.
package pkg_4004;

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_e;

    typedef enum logic [1:0] {
        DB_IDLE = 2'd0,
        DB_ROM  = 2'd1,
        DB_RAM  = 2'd2
    } db_sel_e;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_e;

    localparam logic [3:0] OPR_IO = 4'hE;

    // I/O read group: OPR=E with OPA in 8..F.
    function automatic logic is_io_read(input logic [3:0] opr, input logic [3:0] opa);
        return (opr == OPR_IO) && opa[3];
    endfunction

endpackage

// File: rtl/phase_tracker_4004.sv
// clk2 rising-edge detect, lock FSM and 8-phase counter for the 4004 bus cycle.
// state       | meaning
// ST_UNLOCKED | waiting for a step with sync high; phase not valid
// ST_LOCKED   | phase advances on every step, sync expected only at X3
module phase_tracker_4004
    import pkg_4004::*;
#(
    parameter bit SYNC_CHECK = 1'b1
) (
    input  logic   eclk,
    input  logic   ereset_n,
    input  logic   i_clk2,
    input  logic   i_sync,
    output logic   o_step,
    output logic   o_lose,
    output logic   o_locked,
    output phase_e o_phase,
    output logic   o_locked_nxt,
    output phase_e o_phase_nxt,
    output logic   o_sync_err
);

    logic   r_clk2_q;
    lock_e  r_state;
    lock_e  w_state_nxt;
    phase_e r_phase;
    phase_e w_phase_nxt;
    logic   r_sync_err;
    logic   w_err_nxt;
    logic   w_step;
    logic   w_lose;

    assign w_step = i_clk2 & ~r_clk2_q;

    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            r_clk2_q   <= 1'b0;
            r_state    <= ST_UNLOCKED;
            r_phase    <= PH_A1;
            r_sync_err <= 1'b0;
        end else begin
            r_clk2_q   <= i_clk2;
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_sync_err <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_err_nxt   = r_sync_err;
        w_lose      = 1'b0;
        if (w_step) begin
            case (r_state)
                ST_UNLOCKED: begin
                    if (i_sync) begin
                        w_state_nxt = ST_LOCKED;
                        w_phase_nxt = PH_A1;
                    end
                end
                ST_LOCKED: begin
                    // Missing sync at X3, or an early sync when checking, drops lock.
                    if (r_phase == PH_X3) w_lose = ~i_sync;
                    else                  w_lose = i_sync & SYNC_CHECK;
                    if (w_lose) begin
                        w_state_nxt = ST_UNLOCKED;
                        w_err_nxt   = 1'b1;
                    end else if (i_sync) begin
                        w_phase_nxt = PH_A1;
                    end else begin
                        w_phase_nxt = phase_e'(r_phase + 3'd1);
                    end
                end
            endcase
        end
    end

    assign o_step       = w_step;
    assign o_lose       = w_lose;
    assign o_locked     = (r_state == ST_LOCKED);
    assign o_phase      = r_phase;
    assign o_locked_nxt = (w_state_nxt == ST_LOCKED);
    assign o_phase_nxt  = w_phase_nxt;
    assign o_sync_err   = r_sync_err;

endmodule

// File: rtl/bus_seq_4004.sv
// 4004 bus-cycle sequencer: latches fetch address, OPR/OPA and SRC address,
// and selects the db_i source (idle/ROM/RAM) one eclk after each phase step.
module bus_seq_4004
    import pkg_4004::*;
#(
    parameter bit SYNC_CHECK = 1'b1
) (
    input  logic        eclk,
    input  logic        ereset_n,
    input  logic        clk2,
    input  logic        sync,
    input  logic        cm_rom,
    input  logic [3:0]  cm_ram,
    input  logic [3:0]  db_o,
    output logic [2:0]  phase,
    output logic        locked,
    output logic        sync_err,
    output logic [11:0] rom_addr,
    output logic        addr_vld,
    output logic [3:0]  opr,
    output logic [3:0]  opa,
    output logic        inst_vld,
    output logic [7:0]  src_addr,
    output logic [3:0]  src_bank,
    output logic        src_vld,
    output logic [1:0]  db_sel
);

    logic    w_step;
    logic    w_lose;
    logic    w_locked;
    phase_e  w_phase;
    logic    w_locked_nxt;
    phase_e  w_phase_nxt;
    logic    w_cap;
    logic    w_rom_cs_nxt;
    db_sel_e w_db_sel_nxt;

    logic [11:0] r_rom_addr;
    logic        r_addr_vld;
    logic        r_rom_cs;
    logic [3:0]  r_opr;
    logic [3:0]  r_opa;
    logic        r_inst_vld;
    logic [7:0]  r_src_addr;
    logic [3:0]  r_src_bank;
    logic        r_src_pend;
    logic        r_src_vld;
    db_sel_e     r_db_sel;

    phase_tracker_4004 #(.SYNC_CHECK(SYNC_CHECK)) u_tracker (
        .eclk         (eclk),
        .ereset_n     (ereset_n),
        .i_clk2       (clk2),
        .i_sync       (sync),
        .o_step       (w_step),
        .o_lose       (w_lose),
        .o_locked     (w_locked),
        .o_phase      (w_phase),
        .o_locked_nxt (w_locked_nxt),
        .o_phase_nxt  (w_phase_nxt),
        .o_sync_err   (sync_err)
    );

    // Captures only happen on steps that keep the tracker locked.
    assign w_cap = w_step & w_locked & ~w_lose;

    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            r_rom_addr <= '0;
            r_addr_vld <= 1'b0;
            r_rom_cs   <= 1'b0;
            r_opr      <= '0;
            r_opa      <= '0;
            r_inst_vld <= 1'b0;
            r_src_addr <= '0;
            r_src_bank <= '0;
            r_src_pend <= 1'b0;
            r_src_vld  <= 1'b0;
            r_db_sel   <= DB_IDLE;
        end else begin
            r_addr_vld <= 1'b0;
            r_inst_vld <= 1'b0;
            r_src_vld  <= 1'b0;
            r_db_sel   <= w_db_sel_nxt;
            if (w_lose) r_src_pend <= 1'b0;
            if (w_cap) begin
                case (w_phase)
                    PH_A1: r_rom_addr[3:0] <= db_o;
                    PH_A2: r_rom_addr[7:4] <= db_o;
                    PH_A3: begin
                        r_rom_addr[11:8] <= db_o;
                        r_rom_cs         <= cm_rom;
                        r_addr_vld       <= 1'b1;
                    end
                    PH_M1: r_opr <= db_o;
                    PH_M2: begin
                        r_opa      <= db_o;
                        r_inst_vld <= 1'b1;
                    end
                    PH_X2: begin
                        if (|cm_ram) begin
                            r_src_addr[7:4] <= db_o;
                            r_src_bank      <= cm_ram;
                            r_src_pend      <= 1'b1;
                        end
                    end
                    PH_X3: begin
                        if (r_src_pend) begin
                            r_src_addr[3:0] <= db_o;
                            r_src_vld       <= 1'b1;
                            r_src_pend      <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // db_sel is decoded from the phase being entered so it lines up with that phase.
    always_comb begin
        w_rom_cs_nxt = (w_cap && (w_phase == PH_A3)) ? cm_rom : r_rom_cs;
        w_db_sel_nxt = DB_IDLE;
        if (w_locked_nxt) begin
            if (((w_phase_nxt == PH_M1) || (w_phase_nxt == PH_M2)) && w_rom_cs_nxt)
                w_db_sel_nxt = DB_ROM;
            else if ((w_phase_nxt == PH_X2) && is_io_read(r_opr, r_opa))
                w_db_sel_nxt = DB_RAM;
        end
    end

    assign phase    = w_phase;
    assign locked   = w_locked;
    assign rom_addr = r_rom_addr;
    assign addr_vld = r_addr_vld;
    assign opr      = r_opr;
    assign opa      = r_opa;
    assign inst_vld = r_inst_vld;
    assign src_addr = r_src_addr;
    assign src_bank = r_src_bank;
    assign src_vld  = r_src_vld;
    assign db_sel   = r_db_sel;

endmodule

// File: tb/tb_bus_seq_4004.sv
// Self-checking bench for bus_seq_4004: directed vector table, hand-written
// lock/reset sequences, then random bus traffic against a per-step reference model.
module tb_bus_seq_4004;

    logic        eclk = 1'b0;
    logic        ereset_n = 1'b0;
    logic        clk2 = 1'b0;
    logic        sync = 1'b0;
    logic        cm_rom = 1'b0;
    logic [3:0]  cm_ram = '0;
    logic [3:0]  db_o = '0;
    logic [2:0]  phase;
    logic        locked;
    logic        sync_err;
    logic [11:0] rom_addr;
    logic        addr_vld;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic        inst_vld;
    logic [7:0]  src_addr;
    logic [3:0]  src_bank;
    logic        src_vld;
    logic [1:0]  db_sel;

    bus_seq_4004 #(.SYNC_CHECK(1'b1)) dut (
        .eclk(eclk), .ereset_n(ereset_n), .clk2(clk2), .sync(sync),
        .cm_rom(cm_rom), .cm_ram(cm_ram), .db_o(db_o),
        .phase(phase), .locked(locked), .sync_err(sync_err),
        .rom_addr(rom_addr), .addr_vld(addr_vld), .opr(opr), .opa(opa),
        .inst_vld(inst_vld), .src_addr(src_addr), .src_bank(src_bank),
        .src_vld(src_vld), .db_sel(db_sel)
    );

    always #5 eclk = ~eclk;

    int checks = 0;
    int failures = 0;

    // Reference model state (what the bus cycle should have produced so far).
    bit        m_locked, m_err, m_rom_cs, m_pend;
    int        m_phase;
    bit [11:0] m_addr;
    bit [3:0]  m_opr, m_opa, m_bank;
    bit [7:0]  m_src;
    bit        e_av, e_iv, e_sv;
    logic      p_av, p_iv, p_sv;

    typedef struct {
        logic       s;
        logic [3:0] d;
        logic       cr;
        logic [3:0] cm;
        logic [2:0] ph;
        logic [1:0] dbs;
        logic [2:0] pl;   // {addr_vld, inst_vld, src_vld}
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [3:0] d, input logic cr,
                                input logic [3:0] cm, input logic [2:0] ph,
                                input logic [1:0] dbs, input logic [2:0] pl);
        vec_t v;
        v.s = s; v.d = d; v.cr = cr; v.cm = cm; v.ph = ph; v.dbs = dbs; v.pl = pl;
        return v;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_err = 0; m_rom_cs = 0; m_pend = 0; m_phase = 0;
        m_addr = 0; m_opr = 0; m_opa = 0; m_bank = 0; m_src = 0;
        e_av = 0; e_iv = 0; e_sv = 0;
    endtask

    task automatic model_step(input bit s, input bit [3:0] d, input bit cr, input bit [3:0] cm);
        bit lose;
        e_av = 0; e_iv = 0; e_sv = 0;
        if (!m_locked) begin
            if (s) begin m_locked = 1; m_phase = 0; end
        end else begin
            lose = (m_phase == 7) ? !s : s;
            if (lose) begin
                m_locked = 0; m_err = 1; m_pend = 0;
            end else begin
                case (m_phase)
                    0: m_addr[3:0]  = d;
                    1: m_addr[7:4]  = d;
                    2: begin m_addr[11:8] = d; m_rom_cs = cr; e_av = 1; end
                    3: m_opr = d;
                    4: begin m_opa = d; e_iv = 1; end
                    6: if (cm != 0) begin m_src[7:4] = d; m_bank = cm; m_pend = 1; end
                    7: if (m_pend) begin m_src[3:0] = d; e_sv = 1; m_pend = 0; end
                    default: ;
                endcase
                m_phase = (m_phase + 1) % 8;
            end
        end
    endtask

    function automatic int exp_db();
        if (!m_locked) return 0;
        if ((m_phase == 3 || m_phase == 4) && m_rom_cs) return 1;
        if (m_phase == 6 && m_opr == 4'hE && m_opa >= 4'h8) return 2;
        return 0;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".locked"},   locked,   m_locked);
        chk({tag, ".sync_err"}, sync_err, m_err);
        if (m_locked) chk({tag, ".phase"}, phase, m_phase);
        chk({tag, ".rom_addr"}, rom_addr, m_addr);
        chk({tag, ".opr"},      opr,      m_opr);
        chk({tag, ".opa"},      opa,      m_opa);
        chk({tag, ".src_addr"}, src_addr, m_src);
        chk({tag, ".src_bank"}, src_bank, m_bank);
        chk({tag, ".db_sel"},   db_sel,   exp_db());
        chk({tag, ".addr_vld"}, p_av,     e_av);
        chk({tag, ".inst_vld"}, p_iv,     e_iv);
        chk({tag, ".src_vld"},  p_sv,     e_sv);
    endtask

    // One clk2 period: rising edge gives the step; pulses are sampled just after
    // it and must be gone one eclk later.
    task automatic do_step(input logic s, input logic [3:0] d, input logic cr,
                           input logic [3:0] cm, input string tag);
        @(negedge eclk);
        sync = s; db_o = d; cm_rom = cr; cm_ram = cm; clk2 = 1'b1;
        @(posedge eclk); #1;
        p_av = addr_vld; p_iv = inst_vld; p_sv = src_vld;
        model_step(s, d, cr, cm);
        @(negedge eclk);
        clk2 = 1'b0;
        @(posedge eclk); #1;
        chk({tag, ".pulse_width"}, {29'd0, addr_vld, inst_vld, src_vld}, 0);
        @(posedge eclk); #1;
        check_model(tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".phase"}, phase, 0);
        chk({tag, ".locked"}, locked, 0);
        chk({tag, ".sync_err"}, sync_err, 0);
        chk({tag, ".rom_addr"}, rom_addr, 0);
        chk({tag, ".opr_opa"}, {opr, opa}, 0);
        chk({tag, ".src"}, {src_addr, src_bank}, 0);
        chk({tag, ".pulses"}, {addr_vld, inst_vld, src_vld}, 0);
        chk({tag, ".db_sel"}, db_sel, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        p_av = 0; p_iv = 0; p_sv = 0;

        // Fetch 3A5 with ROM select, RDM (E9) with SRC 7C on bank 2, then a plain cycle.
        tbl[0]  = mk(1, 4'h0, 0, 4'h0, 3'd0, 2'd0, 3'b000);
        tbl[1]  = mk(0, 4'h5, 0, 4'h0, 3'd1, 2'd0, 3'b000);
        tbl[2]  = mk(0, 4'hA, 0, 4'h0, 3'd2, 2'd0, 3'b000);
        tbl[3]  = mk(0, 4'h3, 1, 4'h0, 3'd3, 2'd1, 3'b100);
        tbl[4]  = mk(0, 4'hE, 0, 4'h0, 3'd4, 2'd1, 3'b000);
        tbl[5]  = mk(0, 4'h9, 0, 4'h0, 3'd5, 2'd0, 3'b010);
        tbl[6]  = mk(0, 4'h0, 0, 4'h0, 3'd6, 2'd2, 3'b000);
        tbl[7]  = mk(0, 4'h7, 0, 4'h2, 3'd7, 2'd0, 3'b000);
        tbl[8]  = mk(1, 4'hC, 0, 4'h0, 3'd0, 2'd0, 3'b001);
        tbl[9]  = mk(0, 4'h0, 0, 4'h0, 3'd1, 2'd0, 3'b000);
        tbl[10] = mk(0, 4'h0, 0, 4'h0, 3'd2, 2'd0, 3'b000);
        tbl[11] = mk(0, 4'h0, 0, 4'h0, 3'd3, 2'd0, 3'b100);
        tbl[12] = mk(0, 4'hE, 0, 4'h0, 3'd4, 2'd0, 3'b000);
        tbl[13] = mk(0, 4'h4, 0, 4'h0, 3'd5, 2'd0, 3'b010);
        tbl[14] = mk(0, 4'h0, 0, 4'h0, 3'd6, 2'd0, 3'b000);
        tbl[15] = mk(0, 4'h0, 0, 4'h0, 3'd7, 2'd0, 3'b000);
        tbl[16] = mk(1, 4'h0, 0, 4'h0, 3'd0, 2'd0, 3'b000);

        repeat (3) @(posedge eclk);
        #1 check_all_zero("reset");
        @(negedge eclk) ereset_n = 1'b1;
        repeat (2) @(posedge eclk);

        do_step(0, 4'h0, 0, 4'h0, "prelock");
        chk("prelock.locked", locked, 0);

        for (int i = 0; i < 17; i++) begin
            do_step(tbl[i].s, tbl[i].d, tbl[i].cr, tbl[i].cm, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_locked", i), locked, 1);
            chk($sformatf("vec%0d.tbl_phase", i), phase, tbl[i].ph);
            chk($sformatf("vec%0d.tbl_db_sel", i), db_sel, tbl[i].dbs);
            chk($sformatf("vec%0d.tbl_pulses", i), {p_av, p_iv, p_sv}, tbl[i].pl);
            chk($sformatf("vec%0d.tbl_sync_err", i), sync_err, 0);
            if (i == 8) begin
                chk("cyc1.rom_addr", rom_addr, 12'h3A5);
                chk("cyc1.opr_opa", {opr, opa}, 8'hE9);
                chk("cyc1.src_addr", src_addr, 8'h7C);
                chk("cyc1.src_bank", src_bank, 4'h2);
            end
        end
        chk("cyc2.rom_addr", rom_addr, 12'h000);
        chk("cyc2.opa", opa, 4'h4);

        // Withhold sync at X3: lock lost, sticky error, relock later.
        for (int i = 0; i < 7; i++) do_step(0, 4'(i), 0, 4'h0, "miss");
        do_step(0, 4'h1, 0, 4'h0, "miss_x3");
        chk("miss_x3.locked", locked, 0);
        chk("miss_x3.sync_err", sync_err, 1);
        chk("miss_x3.db_sel", db_sel, 0);
        for (int i = 0; i < 3; i++) do_step(0, 4'h0, 0, 4'h0, "unlocked");
        do_step(1, 4'h0, 0, 4'h0, "relock");
        chk("relock.locked", locked, 1);
        chk("relock.sync_err", sync_err, 1);

        // Early sync at A2 drops lock; relock, then lose lock in M1 with ROM selected.
        do_step(0, 4'h0, 0, 4'h0, "early_a1");
        do_step(1, 4'h0, 0, 4'h0, "early_a2");
        chk("early.locked", locked, 0);
        do_step(1, 4'h0, 0, 4'h0, "relock2");
        do_step(0, 4'h1, 0, 4'h0, "m1loss_a1");
        do_step(0, 4'h2, 0, 4'h0, "m1loss_a2");
        do_step(0, 4'h3, 1, 4'h0, "m1loss_a3");
        chk("m1loss.db_rom", db_sel, 1);
        do_step(1, 4'h0, 0, 4'h0, "m1loss_sync");
        chk("m1loss.db_sel", db_sel, 0);
        chk("m1loss.rom_addr_held", rom_addr, 12'h321);

        // Asynchronous reset while in M1 with db_sel=ROM.
        do_step(1, 4'h0, 0, 4'h0, "rst_lock");
        do_step(0, 4'h4, 0, 4'h0, "rst_a1");
        do_step(0, 4'h5, 0, 4'h0, "rst_a2");
        do_step(0, 4'h6, 1, 4'h0, "rst_a3");
        chk("rst_pre.db_sel", db_sel, 1);
        #3 ereset_n = 1'b0;
        #1 check_all_zero("rst_mid");
        model_reset();
        @(negedge eclk) ereset_n = 1'b1;
        do_step(0, 4'h0, 0, 4'h0, "rst_post0");
        do_step(0, 4'h0, 1, 4'h0, "rst_post1");
        chk("rst_post.locked", locked, 0);
        do_step(1, 4'h0, 0, 4'h0, "rst_relock");
        do_step(0, 4'h7, 0, 4'h0, "rst_b_a1");
        do_step(0, 4'h8, 0, 4'h0, "rst_b_a2");
        do_step(0, 4'h9, 1, 4'h0, "rst_b_a3");
        chk("rst_b.addr_vld", p_av, 1);
        chk("rst_b.rom_addr", rom_addr, 12'h987);

        // Random traffic with occasional sync faults.
        for (int n = 0; n < 600; n++) begin
            logic       s;
            logic [3:0] d;
            logic [3:0] cm;
            if (!m_locked || m_phase == 7) s = ($urandom_range(0, 9) != 0);
            else                           s = ($urandom_range(0, 39) == 0);
            d  = 4'($urandom);
            if (m_phase == 3 && $urandom_range(0, 1) == 1) d = 4'hE;
            cm = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            do_step(s, d, 1'($urandom), cm, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
